// File: rtl/aso_pkg.sv
// Shared types and fixed-point constants for the ASO scheduler.
// aso_calc computes one rounded result from a sample and its fourth-oldest history.
package aso_pkg;

    localparam int ZW          = 11;
    localparam int PW          = 12;
    localparam int FRAC        = 10;
    localparam int ROUND_CONST = 512;

    typedef logic signed [ZW-1:0]   sample_t;
    typedef logic signed [2*ZW-1:0] prod_t;
    typedef logic signed [PW-1:0]   result_t;

    // The difference wraps at ZW bits before the multiply.
    function automatic result_t aso_calc(input sample_t s, input sample_t h4);
        sample_t d;
        prod_t   prod;
        prod_t   acc;
        d    = s - h4;
        prod = prod_t'(d) * prod_t'(s);
        acc  = prod + prod_t'(ROUND_CONST);
        return result_t'(acc[2*ZW-1:FRAC]);
    endfunction

endpackage

// File: rtl/aso_sched_if.sv
// Sample-in / result-out handshake bundle for aso_sched.
interface aso_sched_if #(
    parameter int NCH = 4,
    parameter int ZW  = 11,
    parameter int PW  = 12
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0][ZW-1:0] z;
    logic [NCH-1:0]         z_valid;
    logic [NCH-1:0]         z_ready;
    logic signed [PW-1:0]   p;
    logic [CW-1:0]          p_ch;
    logic                   p_valid;
    logic                   p_ready;

    modport master (output z, z_valid, p_ready, input z_ready, p, p_ch, p_valid);
    modport slave  (input z, z_valid, p_ready, output z_ready, p, p_ch, p_valid);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr, grants at most one requester when en,
// then moves ptr to one past the granted index.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx,
    output logic           gnt_vld
);

    logic [CW-1:0] ptr_r;
    logic [CW-1:0] ptr_nxt_s;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_vld = 1'b0;
        gnt_idx = {CW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            cand = int'(ptr_r) + i;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end else begin
                cand = cand;
            end
            if (en && !gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(cand);
            end else begin
                gnt_vld = gnt_vld;
            end
        end
        gnt = gnt_vld ? (NCH'(1'b1) << gnt_idx) : {NCH{1'b0}};
    end

    assign ptr_nxt_s = (gnt_idx == CW'(NCH - 1)) ? {CW{1'b0}} : gnt_idx + CW'(1'b1);

    // Pointer register, advanced only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= {CW{1'b0}};
        end else if (clr) begin
            ptr_r <= {CW{1'b0}};
        end else if (gnt_vld) begin
            ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/aso_sched.sv
// Multi-channel ASO scheduler: per-channel sample holding and 4-deep history,
// one shared datapath issued round-robin, registered result with backpressure.
module aso_sched #(
    parameter int NCH = 4,
    parameter int ZW  = 11,
    parameter int PW  = 12
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    aso_sched_if.slave bus
);
    import aso_pkg::*;

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       pend_r;
    logic signed [ZW-1:0] hold_r [NCH];
    logic signed [ZW-1:0] hist_r [NCH][4];
    logic signed [PW-1:0] p_r;
    logic [CW-1:0]        p_ch_r;
    logic                 p_valid_r;

    logic                 issue_en_s;
    logic [NCH-1:0]       cap_s;
    logic [NCH-1:0]       gnt_s;
    logic [CW-1:0]        gnt_idx_s;
    logic                 gnt_vld_s;
    logic signed [PW-1:0] res_s;

    // A stalled result blocks issue; clear blocks everything.
    assign issue_en_s = (|pend_r) && (!p_valid_r || bus.p_ready) && !clr;
    assign cap_s      = bus.z_valid & ~pend_r;
    assign res_s      = aso_calc(hold_r[gnt_idx_s], hist_r[gnt_idx_s][3]);

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (issue_en_s),
        .req     (pend_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (gnt_vld_s)
    );

    // Per-channel capture, pending flag and history shift on issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= {NCH{1'b0}};
            for (int c = 0; c < NCH; c++) begin
                hold_r[c] <= {ZW{1'b0}};
                for (int k = 0; k < 4; k++) hist_r[c][k] <= {ZW{1'b0}};
            end
        end else if (clr) begin
            pend_r <= {NCH{1'b0}};
            for (int c = 0; c < NCH; c++) begin
                hold_r[c] <= {ZW{1'b0}};
                for (int k = 0; k < 4; k++) hist_r[c][k] <= {ZW{1'b0}};
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cap_s[c]) begin
                    hold_r[c] <= $signed(bus.z[c]);
                    pend_r[c] <= 1'b1;
                end else if (gnt_s[c]) begin
                    pend_r[c]    <= 1'b0;
                    hist_r[c][0] <= hold_r[c];
                    hist_r[c][1] <= hist_r[c][0];
                    hist_r[c][2] <= hist_r[c][1];
                    hist_r[c][3] <= hist_r[c][2];
                end
            end
        end
    end

    // Result register; holds while valid and not accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_r       <= {PW{1'b0}};
            p_ch_r    <= {CW{1'b0}};
            p_valid_r <= 1'b0;
        end else if (clr) begin
            p_valid_r <= 1'b0;
        end else if (gnt_vld_s) begin
            p_r       <= res_s;
            p_ch_r    <= gnt_idx_s;
            p_valid_r <= 1'b1;
        end else if (bus.p_ready) begin
            p_valid_r <= 1'b0;
        end
    end

    assign bus.z_ready = ~pend_r;
    assign bus.p       = p_r;
    assign bus.p_ch    = p_ch_r;
    assign bus.p_valid = p_valid_r;

endmodule

// File: tb/tb_aso_sched.sv
// Self-checking bench for aso_sched: directed scenarios plus random traffic
// against a transaction-level reference model using plain integer arithmetic.
module tb_aso_sched;
    import aso_pkg::*;

    localparam int NCH = 4;

    logic clk;
    logic rst;
    logic clr;
    int   n_pass;
    int   n_total;

    aso_sched_if #(.NCH(NCH), .ZW(ZW), .PW(PW)) bus ();

    aso_sched #(.NCH(NCH), .ZW(ZW), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit m_pend [NCH];
    int m_hold [NCH];
    int m_hist [NCH][4];
    int m_ptr;
    bit m_pv;
    int m_p;
    int m_pch;

    function automatic int m_aso(int s, int h4);
        int d;
        int prod;
        d = (s - h4) & 2047;
        if (d >= 1024) d = d - 2048;
        prod = d * s;
        return (prod + 512) >>> 10;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pend[c] = 1'b0;
            m_hold[c] = 0;
            for (int k = 0; k < 4; k++) m_hist[c][k] = 0;
        end
        m_ptr = 0;
        m_pv  = 1'b0;
        m_p   = 0;
        m_pch = 0;
    endfunction

    function automatic void model_step(logic [3:0] zv, logic [3:0][10:0] zs, logic pr, logic cl);
        bit old_pend [NCH];
        bit any;
        int g;
        if (cl) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 1'b0;
                m_hold[c] = 0;
                for (int k = 0; k < 4; k++) m_hist[c][k] = 0;
            end
            m_ptr = 0;
            m_pv  = 1'b0;
            return;
        end
        any = 1'b0;
        g   = -1;
        for (int c = 0; c < NCH; c++) begin
            old_pend[c] = m_pend[c];
            if (m_pend[c]) any = 1'b1;
        end
        if (any && (!m_pv || pr)) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
            m_p  = m_aso(m_hold[g], m_hist[g][3]);
            m_pch = g;
            m_pv = 1'b1;
            for (int k = 3; k > 0; k--) m_hist[g][k] = m_hist[g][k-1];
            m_hist[g][0] = m_hold[g];
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % NCH;
        end else if (pr) begin
            m_pv = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (zv[c] && !old_pend[c]) begin
                m_pend[c] = 1'b1;
                m_hold[c] = int'($signed(zs[c]));
            end
        end
    endfunction

    function automatic logic [18:0] model_vec();
        logic [3:0] zr;
        for (int c = 0; c < NCH; c++) zr[c] = !m_pend[c];
        return {m_pv, 2'(m_pch), 12'(m_p), zr};
    endfunction

    function automatic logic [3:0][10:0] rand_zs();
        logic [3:0][10:0] v;
        for (int c = 0; c < NCH; c++) v[c] = 11'($urandom);
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic drive(input logic [3:0] zv, input logic [3:0][10:0] zs, input logic pr, input logic cl);
        bus.z_valid = zv;
        bus.z       = zs;
        bus.p_ready = pr;
        clr         = cl;
        @(posedge clk);
        model_step(zv, zs, pr, cl);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if ({bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== {1'b0, 2'd0, 12'd0, 4'hf})
            $display("FAIL reset_state: got v=%b ch=%0d p=%0d zr=%b want v=0 ch=0 p=0 zr=1111",
                     bus.p_valid, bus.p_ch, $signed(bus.p), bus.z_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if ({bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
            $display("FAIL reset_idle: got %h want %h", {bus.p_valid, bus.p_ch, bus.p, bus.z_ready}, model_vec());
        else n_pass++;
    endtask

    task automatic test_ch0_seq();
        int smp [5] = '{100, 200, 300, 400, 500};
        int exp [5] = '{10, 39, 88, 156, 195};
        logic [3:0][10:0] zs;
        drive(4'b0000, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            zs = '0;
            zs[0] = 11'(smp[i]);
            drive(4'b0001, zs, 1'b1, 1'b0);
            drive(4'b0000, zs, 1'b1, 1'b0);
            n_total++;
            if (bus.p_valid !== 1'b1 || $signed(bus.p) != exp[i] || bus.p_ch !== 2'd0)
                $display("FAIL ch0_seq[%0d]: got v=%b p=%0d ch=%0d want v=1 p=%0d ch=0",
                         i, bus.p_valid, $signed(bus.p), bus.p_ch, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int seq [5] = '{-1024, 0, 0, 0, 1023};
        logic [3:0][10:0] zs;
        drive(4'b0000, '0, 1'b1, 1'b1);
        zs = '0;
        zs[1] = 11'h400;
        drive(4'b0010, zs, 1'b1, 1'b0);
        drive(4'b0000, zs, 1'b1, 1'b0);
        n_total++;
        if (bus.p_valid !== 1'b1 || $signed(bus.p) != 1024 || bus.p_ch !== 2'd1)
            $display("FAIL wrap_ch1: got v=%b p=%0d ch=%0d want v=1 p=1024 ch=1",
                     bus.p_valid, $signed(bus.p), bus.p_ch);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            zs = '0;
            zs[2] = 11'(seq[i]);
            drive(4'b0100, zs, 1'b1, 1'b0);
            drive(4'b0000, zs, 1'b1, 1'b0);
            n_total++;
            if ({bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
                $display("FAIL wrap_ch2_model[%0d]: got %h want %h", i,
                         {bus.p_valid, bus.p_ch, bus.p, bus.z_ready}, model_vec());
            else n_pass++;
        end
        n_total++;
        if ($signed(bus.p) != -1 || bus.p_ch !== 2'd2)
            $display("FAIL wrap_ch2: got p=%0d ch=%0d want p=-1 ch=2", $signed(bus.p), bus.p_ch);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        drive(4'b0000, '0, 1'b1, 1'b1);
        drive(4'b1111, rand_zs(), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0000, '0, 1'b1, 1'b0);
            n_total++;
            if (bus.p_valid !== 1'b1 || bus.p_ch !== 2'(k) ||
                {bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
                $display("FAIL rr_order[%0d]: got v=%b ch=%0d p=%0d want v=1 ch=%0d p=%0d",
                         k, bus.p_valid, bus.p_ch, $signed(bus.p), k, m_p);
            else n_pass++;
        end
        drive(4'b1001, rand_zs(), 1'b1, 1'b0);
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if (bus.p_ch !== 2'd0 || bus.p_valid !== 1'b1)
            $display("FAIL rr_wrap_first: got ch=%0d v=%b want ch=0 v=1", bus.p_ch, bus.p_valid);
        else n_pass++;
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if (bus.p_ch !== 2'd3 || {bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
            $display("FAIL rr_wrap_second: got ch=%0d p=%0d want ch=3 p=%0d", bus.p_ch, $signed(bus.p), m_p);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        drive(4'b0000, '0, 1'b1, 1'b1);
        drive(4'b0110, rand_zs(), 1'b0, 1'b0);
        drive(4'b0000, '0, 1'b0, 1'b0);
        drive(4'b0010, rand_zs(), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, '0, 1'b0, 1'b0);
            n_total++;
            if (bus.p_valid !== 1'b1 || bus.p_ch !== 2'd1 || (bus.z_ready & 4'b0110) !== 4'b0000 ||
                {bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
                $display("FAIL bp_stall[%0d]: got v=%b ch=%0d p=%0d zr=%b want v=1 ch=1 p=%0d zr=1001",
                         k, bus.p_valid, bus.p_ch, $signed(bus.p), bus.z_ready, m_p);
            else n_pass++;
        end
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if (bus.p_ch !== 2'd2 || {bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
            $display("FAIL bp_resume: got ch=%0d p=%0d want ch=2 p=%0d", bus.p_ch, $signed(bus.p), m_p);
        else n_pass++;
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if (bus.p_ch !== 2'd1 || bus.p_valid !== 1'b1)
            $display("FAIL bp_resume2: got ch=%0d v=%b want ch=1 v=1", bus.p_ch, bus.p_valid);
        else n_pass++;
    endtask

    task automatic test_clr();
        drive(4'b0101, rand_zs(), 1'b0, 1'b0);
        drive(4'b1111, rand_zs(), 1'b1, 1'b1);
        n_total++;
        if (bus.z_ready !== 4'hf || bus.p_valid !== 1'b0 ||
            {bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec())
            $display("FAIL clr_override: got zr=%b v=%b want zr=1111 v=0", bus.z_ready, bus.p_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3:0][10:0] zs;
        drive(4'b0000, '0, 1'b1, 1'b1);
        drive(4'b1111, rand_zs(), 1'b1, 1'b0);
        drive(4'b0000, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== {1'b0, 2'd0, 12'd0, 4'hf})
            $display("FAIL rst_mid: got v=%b ch=%0d p=%0d zr=%b want v=0 ch=0 p=0 zr=1111",
                     bus.p_valid, bus.p_ch, $signed(bus.p), bus.z_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        zs = '0;
        zs[3] = 11'd100;
        drive(4'b1000, zs, 1'b1, 1'b0);
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if (bus.p_valid !== 1'b1 || $signed(bus.p) != 10 || bus.p_ch !== 2'd3)
            $display("FAIL rst_post: got v=%b p=%0d ch=%0d want v=1 p=10 ch=3",
                     bus.p_valid, $signed(bus.p), bus.p_ch);
        else n_pass++;
        drive(4'b0000, '0, 1'b1, 1'b0);
        n_total++;
        if (bus.p_valid !== 1'b0)
            $display("FAIL rst_no_reissue: got v=%b want v=0", bus.p_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), rand_zs(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
            n_total++;
            if ({bus.p_valid, bus.p_ch, bus.p, bus.z_ready} !== model_vec()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got v=%b ch=%0d p=%0d zr=%b want v=%b ch=%0d p=%0d zr=%b",
                             i, bus.p_valid, bus.p_ch, $signed(bus.p), bus.z_ready,
                             m_pv, m_pch, m_p, model_vec()[3:0]);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b0;
        clr         = 1'b0;
        bus.z_valid = 4'b0000;
        bus.z       = '0;
        bus.p_ready = 1'b0;
        model_reset();
        test_reset();
        test_ch0_seq();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_clr();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
